// File: rtl/io_bus_responder_pkg.sv
// Shared register map for the IO window. The core's load mux and software use it too.
package io_bus_responder_pkg;

  localparam int IO_WINDOW_BYTES = 16;

  typedef enum logic [1:0] {
    IO_REG_IN    = 2'd0,
    IO_REG_OUT   = 2'd1,
    IO_REG_EDGE  = 2'd2,
    IO_REG_TIMER = 2'd3
  } io_reg_e;

endpackage

// File: rtl/io_bus_responder_sync_chain.sv
// Multi-bit flop chain that brings asynchronous board inputs into the clock domain.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder on the MEM-stage bus: inputs, outputs, rising-edge flags, timer.
// Read data has the same one-cycle latency as data memory; hit tells the core to take q.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int                    XLEN        = 32,
  parameter int                    ADDR_WIDTH  = 9,
  parameter int                    IO_WIDTH    = 11,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 9'h1F0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [XLEN-1:0]       data,
  input  logic                  wren,
  output logic [XLEN-1:0]       q,
  output logic                  hit,
  input  logic [IO_WIDTH-1:0]   io_input_bus,
  output logic [IO_WIDTH-1:0]   io_output_bus
);

  logic                w_sel;
  logic                w_wr;
  io_reg_e             w_idx;
  logic [IO_WIDTH-1:0] w_in_s;
  logic [IO_WIDTH-1:0] w_rise;
  logic [IO_WIDTH-1:0] w_w1c;
  logic [XLEN-1:0]     w_rdata;
  logic                w_unused;

  logic [IO_WIDTH-1:0] r_in_d;
  logic [IO_WIDTH-1:0] r_out;
  logic [IO_WIDTH-1:0] r_edge;
  logic [XLEN-1:0]     r_timer;
  logic [XLEN-1:0]     r_q;
  logic                r_hit;

  sync_chain #(
    .WIDTH  (IO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_d       (io_input_bus),
    .o_q       (w_in_s)
  );

  // Byte lanes within a word are not decoded.
  assign w_unused = ^address[1:0];

  assign w_sel  = (address[ADDR_WIDTH-1:4] == IO_BASE[ADDR_WIDTH-1:4]);
  assign w_idx  = io_reg_e'(address[3:2]);
  assign w_wr   = wren && w_sel;
  assign w_rise = w_in_s & ~r_in_d;
  assign w_w1c  = (w_wr && (w_idx == IO_REG_EDGE)) ? data[IO_WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      IO_REG_IN:    w_rdata[IO_WIDTH-1:0] = w_in_s;
      IO_REG_OUT:   w_rdata[IO_WIDTH-1:0] = r_out;
      IO_REG_EDGE:  w_rdata[IO_WIDTH-1:0] = r_edge;
      IO_REG_TIMER: w_rdata               = r_timer;
      default:      w_rdata               = '0;
    endcase
  end

  // The read samples pre-write values, so a same-edge store is not visible until next read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_d  <= '0;
      r_out   <= '0;
      r_edge  <= '0;
      r_timer <= '0;
      r_q     <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_in_d <= w_in_s;
      r_edge <= (r_edge & ~w_w1c) | w_rise;
      if (w_wr && (w_idx == IO_REG_OUT)) r_out <= data[IO_WIDTH-1:0];
      if (w_wr && (w_idx == IO_REG_TIMER)) r_timer <= data;
      else                                 r_timer <= r_timer + XLEN'(1);
      r_q   <= w_sel ? w_rdata : '0;
      r_hit <= w_sel;
    end
  end

  assign q             = r_q;
  assign hit           = r_hit;
  assign io_output_bus = r_out;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: a vector table for decode/OUT behaviour plus
// hand sequences for reset, synchroniser latency, edge W1C, timer wrap and async reset.
module tb_io_bus_responder;

  logic        clock;
  logic        reset;
  logic [8:0]  address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic        hit;
  logic [10:0] io_input_bus;
  logic [10:0] io_output_bus;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_q;
    logic        exp_hit;
    logic [10:0] exp_out;
  } vec_t;

  vec_t vecs [11];

  io_bus_responder dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .data          (data),
    .wren          (wren),
    .q             (q),
    .hit           (hit),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [8:0] a, input logic [31:0] d, input logic we);
    address = a;
    data    = d;
    wren    = we;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    vecs[0]  = '{9'h1F4, 32'h0000_05A5, 1'b1, 32'h0,        1'b1, 11'h5A5};
    vecs[1]  = '{9'h1F4, 32'h0,         1'b0, 32'h5A5,      1'b1, 11'h5A5};
    vecs[2]  = '{9'h1F0, 32'h0,         1'b0, 32'h7FF,      1'b1, 11'h5A5};
    vecs[3]  = '{9'h1F0, 32'h0,         1'b1, 32'h7FF,      1'b1, 11'h5A5};
    vecs[4]  = '{9'h1F7, 32'h0,         1'b0, 32'h5A5,      1'b1, 11'h5A5};
    vecs[5]  = '{9'h1F3, 32'h0,         1'b0, 32'h7FF,      1'b1, 11'h5A5};
    vecs[6]  = '{9'h1EC, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b0, 11'h5A5};
    vecs[7]  = '{9'h1F5, 32'hFFFF_F0FF, 1'b1, 32'h5A5,      1'b1, 11'h0FF};
    vecs[8]  = '{9'h1F8, 32'h0,         1'b0, 32'h0,        1'b1, 11'h0FF};
    vecs[9]  = '{9'h000, 32'h0,         1'b0, 32'h0,        1'b0, 11'h0FF};
    vecs[10] = '{9'h1F4, 32'h0,         1'b1, 32'h0FF,      1'b1, 11'h000};

    // Reset held with all inputs high
    reset        = 1'b0;
    io_input_bus = 11'h7FF;
    drive(9'h000, 32'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_q",   q, 32'h0);
    check("rst_hit", {31'h0, hit}, 32'h0);
    check("rst_out", {21'h0, io_output_bus}, 32'h0);

    reset = 1'b1;
    drive(9'h1F8, 32'h0, 1'b0);
    tick();
    check("edge_e1", q, 32'h0);
    check("hit_e1",  {31'h0, hit}, 32'h1);
    tick();
    check("edge_e2", q, 32'h0);
    tick();
    check("edge_e3", q, 32'h0);
    tick();
    check("edge_e4", q, 32'h7FF);

    drive(9'h1F8, 32'h7FF, 1'b1);
    tick();
    check("edge_w1c_q", q, 32'h7FF);
    drive(9'h1F8, 32'h0, 1'b0);
    tick();
    check("edge_cleared", q, 32'h0);

    // Table: decode, OUT, ignored writes
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      tick();
      check($sformatf("vec%0d_q", i),   q, vecs[i].exp_q);
      check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
      check($sformatf("vec%0d_out", i), {21'h0, io_output_bus}, {21'h0, vecs[i].exp_out});
    end

    // Synchroniser latency and rising-edge capture
    io_input_bus = 11'h000;
    drive(9'h1F0, 32'h0, 1'b0);
    repeat (3) tick();
    io_input_bus = 11'h004;
    tick();
    check("in_lat1", q, 32'h0);
    tick();
    check("in_lat2", q, 32'h0);
    tick();
    check("in_lat3", q, 32'h4);
    drive(9'h1F8, 32'h0, 1'b0);
    tick();
    check("edge_set", q, 32'h4);
    drive(9'h1F8, 32'h4, 1'b1);
    tick();
    check("w1c_rbw", q, 32'h4);
    drive(9'h1F8, 32'h0, 1'b0);
    tick();
    check("w1c_clr", q, 32'h0);

    // W1C landing on the same edge as a new rise
    io_input_bus = 11'h000;
    repeat (3) tick();
    check("edge_no_fall", q, 32'h0);
    io_input_bus = 11'h004;
    tick();
    tick();
    drive(9'h1F8, 32'h4, 1'b1);
    tick();
    check("race_rbw", q, 32'h0);
    drive(9'h1F8, 32'h0, 1'b0);
    tick();
    check("race_rise_wins", q, 32'h4);

    // Timer wrap and load-over-increment
    drive(9'h1FC, 32'hFFFF_FFFE, 1'b1);
    tick();
    drive(9'h1FC, 32'h0, 1'b0);
    tick();
    check("tmr_load", q, 32'hFFFF_FFFE);
    tick();
    check("tmr_max", q, 32'hFFFF_FFFF);
    tick();
    check("tmr_wrap", q, 32'h0);
    drive(9'h1FC, 32'h100, 1'b1);
    tick();
    check("tmr_rbw", q, 32'h1);
    drive(9'h1FC, 32'h0, 1'b0);
    tick();
    check("tmr_load_wins", q, 32'h100);
    tick();
    check("tmr_inc", q, 32'h101);

    // Asynchronous reset in the middle of a store
    drive(9'h1F4, 32'h2AA, 1'b1);
    tick();
    check("pre_rst_out", {21'h0, io_output_bus}, 32'h2AA);
    drive(9'h1F4, 32'h155, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out", {21'h0, io_output_bus}, 32'h0);
    check("async_q",   q, 32'h0);
    check("async_hit", {31'h0, hit}, 32'h0);
    #1;
    drive(9'h1F4, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    check("post_rst_out1", {21'h0, io_output_bus}, 32'h0);
    check("post_rst_q",    q, 32'h0);
    tick();
    check("post_rst_out2", {21'h0, io_output_bus}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
